// File: rtl/mmr_router.sv
// Upstream MMR request port fanned out to DEV_COUNT device slaves by address base,
// with per-access handshake, device timeout, decode-error responses and error stats.
module mmr_router #(
  parameter int                DEV_COUNT   = 17,
  parameter int                ADDR_W      = 16,
  parameter int                BASE_ADDR_W = 6,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hBAD0_BAD0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_wr,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [DATA_W-1:0]               req_wdata,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [DATA_W-1:0]               resp_rdata,
  output logic                            resp_err,
  output logic [DEV_COUNT-1:0]            dev_sel,
  output logic                            dev_wr,
  output logic [ADDR_W-BASE_ADDR_W-1:0]   dev_addr,
  output logic [DATA_W-1:0]               dev_wdata,
  input  logic [DEV_COUNT*DATA_W-1:0]     dev_rdata,
  input  logic [DEV_COUNT-1:0]            dev_ack,
  output logic [15:0]                     err_cnt,
  output logic [ADDR_W-1:0]               last_err_addr
);
  localparam int DEV_ADDR_W = ADDR_W - BASE_ADDR_W;
  localparam int CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                 state, state_nxt;
  logic [BASE_ADDR_W-1:0] base_in;
  logic                   decode_ok, hs, ack_hit, tmo_hit;
  logic [DATA_W-1:0]      sel_rdata;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [ADDR_W-1:0]      addr_q;

  assign base_in   = req_addr[ADDR_W-1 -: BASE_ADDR_W];
  assign decode_ok = {1'b0, base_in} < (BASE_ADDR_W+1)'(DEV_COUNT);
  assign hs        = req_valid & req_ready;
  // dev_sel is one-hot on the latched base during WAIT, so it doubles as the ack/rdata mask
  assign ack_hit   = |(dev_ack & dev_sel);
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < DEV_COUNT; i++) begin
      if (dev_sel[i]) sel_rdata = dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = decode_ok ? WAIT : RESP;
      WAIT:    if (ack_hit || tmo_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      dev_sel       <= '0;
      dev_wr        <= 1'b0;
      dev_addr      <= '0;
      dev_wdata     <= '0;
      err_cnt       <= '0;
      last_err_addr <= '0;
      tmo_cnt       <= '0;
      addr_q        <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == RESP);
      case (state)
        IDLE: if (hs) begin
          dev_wr    <= req_wr;
          dev_addr  <= req_addr[DEV_ADDR_W-1:0];
          dev_wdata <= req_wdata;
          addr_q    <= req_addr;
          tmo_cnt   <= '0;
          if (decode_ok) begin
            dev_sel <= DEV_COUNT'(1) << base_in;
          end else begin
            resp_err      <= 1'b1;
            resp_rdata    <= ERR_DATA;
            err_cnt       <= sat_inc16(err_cnt);
            last_err_addr <= req_addr;
          end
        end
        // an ack on the last timeout cycle still completes normally
        WAIT: if (ack_hit) begin
          resp_rdata <= sel_rdata;
          resp_err   <= 1'b0;
          dev_sel    <= '0;
        end else if (tmo_hit) begin
          resp_rdata    <= ERR_DATA;
          resp_err      <= 1'b1;
          dev_sel       <= '0;
          err_cnt       <= sat_inc16(err_cnt);
          last_err_addr <= addr_q;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmr_router.sv
// Directed bench for mmr_router (TIMEOUT = 8): a table of single transactions plus
// hand-written sequences for response backpressure and reset in the middle of an access.
module tb_mmr_router;
  localparam int DEV_COUNT  = 17;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int DEV_ADDR_W = 10;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        req_valid, req_ready, req_wr;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic                        resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0]           resp_rdata;
  logic [DEV_COUNT-1:0]        dev_sel, dev_ack;
  logic                        dev_wr;
  logic [DEV_ADDR_W-1:0]       dev_addr;
  logic [DATA_W-1:0]           dev_wdata;
  logic [DEV_COUNT*DATA_W-1:0] dev_rdata;
  logic [15:0]                 err_cnt;
  logic [ADDR_W-1:0]           last_err_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmr_router #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dev_sel(dev_sel), .dev_wr(dev_wr), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .err_cnt(err_cnt), .last_err_addr(last_err_addr)
  );

  typedef struct {
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    int                    ack_cyc;    // WAIT cycle (1 = first) in which ack_mask is driven, 0 = never
    logic [DEV_COUNT-1:0]  ack_mask;
    logic [DATA_W-1:0]     rdata;      // placed in the selected device's slot
    logic [DEV_COUNT-1:0]  exp_sel;
    logic [DEV_ADDR_W-1:0] exp_daddr;
    logic                  exp_err;
    logic [DATA_W-1:0]     exp_rdata;
    int                    exp_lat;    // cycles from request handshake to resp_valid
    logic [15:0]           exp_err_cnt;
    logic [ADDR_W-1:0]     exp_last;
  } txn_t;

  txn_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rdata(input logic [DEV_COUNT-1:0] sel, input logic [DATA_W-1:0] val);
    for (int i = 0; i < DEV_COUNT; i++)
      dev_rdata[i*DATA_W +: DATA_W] = sel[i] ? val : (32'hEE00_0000 | DATA_W'(i));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"},     64'(req_ready),     64'h0);
    chk({tag, " resp_valid"},    64'(resp_valid),    64'h0);
    chk({tag, " resp_err"},      64'(resp_err),      64'h0);
    chk({tag, " resp_rdata"},    64'(resp_rdata),    64'h0);
    chk({tag, " dev_sel"},       64'(dev_sel),       64'h0);
    chk({tag, " dev_wr"},        64'(dev_wr),        64'h0);
    chk({tag, " dev_addr"},      64'(dev_addr),      64'h0);
    chk({tag, " dev_wdata"},     64'(dev_wdata),     64'h0);
    chk({tag, " err_cnt"},       64'(err_cnt),       64'h0);
    chk({tag, " last_err_addr"}, 64'(last_err_addr), 64'h0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_ready before request"}, 64'(req_ready), 64'h1);
  endtask

  task automatic run_txn(input int idx, input txn_t t);
    string tag;
    int    lat = 0;
    bit    got = 0;
    tag = $sformatf("txn%0d", idx);
    wait_ready(tag);
    set_rdata(t.exp_sel, t.rdata);
    req_valid = 1'b1;
    req_wr    = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (resp_valid) begin
        got = 1;
        lat = c;
      end else begin
        if (c == 1) begin
          chk({tag, " dev_sel"},   64'(dev_sel),   64'(t.exp_sel));
          chk({tag, " dev_addr"},  64'(dev_addr),  64'(t.exp_daddr));
          chk({tag, " dev_wr"},    64'(dev_wr),    64'(t.wr));
          chk({tag, " dev_wdata"}, 64'(dev_wdata), 64'(t.wdata));
          chk({tag, " req_ready in WAIT"}, 64'(req_ready), 64'h0);
        end
        dev_ack = (c == t.ack_cyc) ? t.ack_mask : '0;
        @(negedge clk);
      end
    end
    dev_ack = '0;
    chk({tag, " resp_valid seen"},   64'(got),           64'h1);
    chk({tag, " latency"},           64'(lat),           64'(t.exp_lat));
    chk({tag, " resp_err"},          64'(resp_err),      64'(t.exp_err));
    chk({tag, " resp_rdata"},        64'(resp_rdata),    64'(t.exp_rdata));
    chk({tag, " dev_sel in RESP"},   64'(dev_sel),       64'h0);
    chk({tag, " err_cnt"},           64'(err_cnt),       64'(t.exp_err_cnt));
    chk({tag, " last_err_addr"},     64'(last_err_addr), 64'(t.exp_last));
    @(negedge clk);
    chk({tag, " resp_valid after hs"}, 64'(resp_valid), 64'h0);
    chk({tag, " req_ready after hs"},  64'(req_ready),  64'h1);
  endtask

  initial begin
    //          wr    addr      wdata          ack mask       rdata          exp_sel     daddr   err   exp_rdata     lat cnt   last
    tbl[0] = '{1'b0, 16'h0C10, 32'h0,         5, 17'h00008, 32'h1234_5678, 17'h00008, 10'h010, 1'b0, 32'h1234_5678, 6, 16'd0, 16'h0000};
    tbl[1] = '{1'b0, 16'h4400, 32'h0,         0, 17'h00000, 32'h0,         17'h00000, 10'h000, 1'b1, 32'hBAD0_BAD0, 1, 16'd1, 16'h4400};
    tbl[2] = '{1'b0, 16'h1456, 32'h0,         3, 17'h00040, 32'h0000_DEAD, 17'h00020, 10'h056, 1'b1, 32'hBAD0_BAD0, 9, 16'd2, 16'h1456};
    tbl[3] = '{1'b0, 16'h1C3F, 32'h0,         8, 17'h00080, 32'h0000_00AA, 17'h00080, 10'h03F, 1'b0, 32'h0000_00AA, 9, 16'd2, 16'h1456};
    tbl[4] = '{1'b1, 16'h03FF, 32'h5555_AAAA, 1, 17'h00001, 32'h1111_2222, 17'h00001, 10'h3FF, 1'b0, 32'h1111_2222, 2, 16'd2, 16'h1456};
    tbl[5] = '{1'b0, 16'hFC00, 32'h0,         0, 17'h00000, 32'h0,         17'h00000, 10'h000, 1'b1, 32'hBAD0_BAD0, 1, 16'd3, 16'hFC00};
    tbl[6] = '{1'b0, 16'h4321, 32'h0,         2, 17'h1FFFF, 32'h0F0F_0F0F, 17'h10000, 10'h321, 1'b0, 32'h0F0F_0F0F, 3, 16'd3, 16'hFC00};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    dev_ack    = '0;
    dev_rdata  = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready after reset release", 64'(req_ready), 64'h1);

    for (int i = 0; i < 7; i++) run_txn(i, tbl[i]);

    // Write to device 16 with the response held off for 3 cycles
    wait_ready("bp");
    set_rdata(17'h10000, 32'h0000_0077);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h4004; req_wdata = 32'hCAFE_0001;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp dev_sel",   64'(dev_sel),   64'(17'h10000));
    chk("bp dev_wr",    64'(dev_wr),    64'h1);
    chk("bp dev_wdata", 64'(dev_wdata), 64'hCAFE_0001);
    chk("bp dev_addr",  64'(dev_addr),  64'h004);
    @(negedge clk);
    chk("bp dev_sel held", 64'(dev_sel), 64'(17'h10000));
    dev_ack = 17'h10000;
    @(negedge clk);
    dev_ack = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp resp_valid k%0d", k), 64'(resp_valid), 64'h1);
      chk($sformatf("bp resp_rdata k%0d", k), 64'(resp_rdata), 64'h77);
      chk($sformatf("bp resp_err k%0d", k),   64'(resp_err),   64'h0);
      chk($sformatf("bp req_ready k%0d", k),  64'(req_ready),  64'h0);
      if (k == 3) resp_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp resp_valid after hs", 64'(resp_valid), 64'h0);
    chk("bp req_ready after hs",  64'(req_ready),  64'h1);
    chk("bp err_cnt unchanged",   64'(err_cnt),    64'd3);

    // Reset pulse while waiting on device 2; its late ack must not produce a response
    wait_ready("rst");
    set_rdata(17'h00004, 32'h2222_0002);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0800; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst dev_sel before", 64'(dev_sel), 64'h4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst mid");
    rst_n   = 1'b1;
    dev_ack = 17'h00004;
    @(negedge clk);
    chk("rst req_ready after release", 64'(req_ready), 64'h1);
    chk("rst dev_sel after release",   64'(dev_sel),   64'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst no resp k%0d", k), 64'(resp_valid), 64'h0);
      @(negedge clk);
    end
    dev_ack = '0;
    chk("rst err_cnt", 64'(err_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmr_router.md
Name: mmr_router

Overview:
- Parametrised successor to the fixed MMR address map: one upstream MMR request port from the BAR0 bridge, fanned out to DEV_COUNT device slaves.
- Address split: upper BASE_ADDR_W bits select the device; lower bits go to the device.
- Adds behaviour the fixed map lacks: per-access handshake, timeout on silent devices, decode-error response for unmapped bases, and error statistics.

Parameters:
- DEV_COUNT, 17: number of downstream devices; must satisfy 1 ≤ DEV_COUNT ≤ 2**BASE_ADDR_W.
- ADDR_W, 16: upstream address width.
- BASE_ADDR_W, 6: device-select field width (MSBs of the address).
- DATA_W, 32: data width.
- TIMEOUT, 255: WAIT cycles before timeout; must be ≥ 1.
- ERR_DATA, 32'hBAD0_BAD0: read data returned on any error.
- DEV_ADDR_W is derived as ADDR_W − BASE_ADDR_W; it is a localparam, not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  router can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  upstream accepts response
- resp_rdata  out  DATA_W  read data (ERR_DATA on error)
- resp_err  out  1  response is an error
- dev_sel  out  DEV_COUNT  one-hot device select, held until ack or timeout
- dev_wr  out  1  latched write flag
- dev_addr  out  DEV_ADDR_W  latched device-local address
- dev_wdata  out  DATA_W  latched write data
- dev_rdata  in  DEV_COUNT*DATA_W  device read data, flattened; device i occupies bits [i*DATA_W +: DATA_W]
- dev_ack  in  DEV_COUNT  per-device completion strobe
- err_cnt  out  16  saturating count of error responses
- last_err_addr  out  ADDR_W  address of the most recent errored request

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the clk rising edge.
- Reset values (forced every cycle rst_n = 0):
  - state = IDLE, req_ready = 0, resp_valid = 0, resp_err = 0.
  - resp_rdata = 0, dev_sel = 0, dev_wr = 0, dev_addr = 0, dev_wdata = 0.
  - err_cnt = 0, last_err_addr = 0, timeout counter = 0.
- Reset mid-access: dev_sel drops on the next edge and no response is ever issued for the aborted access.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1 (registered; becomes 1 the first cycle after reset release).
  - Handshake is req_valid & req_ready. On handshake, latch wr, addr, wdata, and base = addr[ADDR_W-1 -: BASE_ADDR_W].
  - base < DEV_COUNT: go to WAIT; dev_sel[base] = 1 from the next cycle; timeout counter cleared.
  - base ≥ DEV_COUNT (decode error): go to RESP with resp_err = 1 and resp_rdata = ERR_DATA. dev_sel is never asserted.
- WAIT:
  - req_ready = 0; dev_sel, dev_wr, dev_addr, dev_wdata are stable.
  - dev_ack[base] = 1: capture dev_rdata slice [base], set resp_err = 0, go to RESP.
  - Writes also capture rdata; the upstream ignores it.
  - dev_ack on any non-selected index is ignored.
  - No ack: increment the counter. When counter == TIMEOUT−1 and no ack, go to RESP with resp_err = 1 and resp_rdata = ERR_DATA.
  - Ack and timeout on the same cycle: the ack wins (normal response).
  - dev_sel clears on the same edge the FSM leaves WAIT.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_valid & resp_ready, then go to IDLE.
  - req_ready returns to 1 the cycle after the response handshake. No request overlaps an outstanding response.
- Latency:
  - Normal access: ack seen in cycle k → resp_valid in cycle k+1.
  - Decode error: request handshake in cycle t → resp_valid in cycle t+1.
  - Timeout: resp_valid exactly TIMEOUT+1 cycles after the request handshake.
- Error statistics:
  - Each entry into RESP with resp_err = 1 increments err_cnt, saturating at 16'hFFFF, and loads last_err_addr with the latched address.
  - Successful responses leave both unchanged.
- Width rules: dev_addr = latched addr[DEV_ADDR_W-1:0]. Base comparison is unsigned, at BASE_ADDR_W bits.

Test Plan:
- Read device 3 at addr 16'h0C10; the device acks 4 cycles after dev_sel with rdata 32'h1234_5678 → dev_sel = 17'h00008, dev_addr = 10'h010, dev_wr = 0. resp_valid comes 1 cycle after the ack with rdata 32'h1234_5678, err = 0. err_cnt stays 0.
- Write to device 16 (addr 16'h4004, wdata 32'hCAFE_0001), ack after 1 cycle, resp_ready held low for 3 cycles → dev_wr = 1, dev_wdata = 32'hCAFE_0001. resp_valid is held 4 cycles with outputs stable. req_ready = 0 until 1 cycle after the response handshake.
- Decode error, addr 16'h4400 (base 17 ≥ DEV_COUNT) → dev_sel stays 0. resp_valid comes next cycle with rdata 32'hBAD0_BAD0, err = 1. err_cnt = 1, last_err_addr = 16'h4400.
- Timeout: TIMEOUT = 8, device 5 never acks, device 6 acks spuriously → the spurious ack is ignored. resp_err = 1 comes exactly 9 cycles after the handshake. dev_sel clears, err_cnt increments.
- Ack on the final timeout cycle (counter = TIMEOUT−1) with rdata 32'h0000_00AA → normal response, rdata 32'h0000_00AA, err = 0, err_cnt unchanged.
- rst_n pulsed low for 1 cycle while in WAIT on device 2 → all outputs reset to 0. A later ack from device 2 produces no response. req_ready returns to 1 one cycle after rst_n goes high.
